// File: rtl/block_nest_if.sv
// Character-stream bus for the keyword nesting checker: the byte source
// drives in/in_valid, the checker returns its nesting status.
//
// Handshake: there is no back-pressure. A byte is consumed on every rising
// clock edge where in_valid is 1; in_valid=0 is a bubble and changes nothing.
interface block_nest_if #(
    parameter int DEPTH_W = 4
) ();
    logic               in_valid;
    logic [7:0]         in;
    logic               result;
    logic [DEPTH_W-1:0] depth;
    logic               top_kind;
    logic               err;
    logic [1:0]         err_code;

    // Byte source side.
    modport master (
        output in_valid, in,
        input  result, depth, top_kind, err, err_code
    );

    // Checker side.
    modport slave (
        input  in_valid, in,
        output result, depth, top_kind, err, err_code
    );
endinterface

// File: rtl/block_nest_checker.sv
// Streaming checker for begin/end (kind 0) and case/endcase (kind 1) nesting.
// A word tracker narrows four keyword candidates byte by byte; a space
// commits the finished word to a small bit stack of open block kinds.
// The first error freezes all state until reset.
module block_nest_checker #(
    parameter int MAX_DEPTH        = 8,
    parameter int DEPTH_W          = 4,
    parameter int CASE_INSENSITIVE = 1
) (
    input logic         clk,
    input logic         reset_n,
    block_nest_if.slave bus
);

    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_MISMATCH  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd3;
    localparam logic [3:0] LEN_SAT       = 4'd8;

    // Keyword index: 0 begin, 1 end, 2 case, 3 endcase.
    function automatic logic [3:0] kw_len(input logic [1:0] k);
        case (k)
            2'd0:    kw_len = 4'd5;
            2'd1:    kw_len = 4'd3;
            2'd2:    kw_len = 4'd4;
            default: kw_len = 4'd7;
        endcase
    endfunction

    function automatic logic [7:0] kw_char(input logic [1:0] k, input logic [2:0] p);
        kw_char = 8'h00;
        case (k)
            2'd0: case (p)
                3'd0: kw_char = "b";
                3'd1: kw_char = "e";
                3'd2: kw_char = "g";
                3'd3: kw_char = "i";
                3'd4: kw_char = "n";
                default: kw_char = 8'h00;
            endcase
            2'd1: case (p)
                3'd0: kw_char = "e";
                3'd1: kw_char = "n";
                3'd2: kw_char = "d";
                default: kw_char = 8'h00;
            endcase
            2'd2: case (p)
                3'd0: kw_char = "c";
                3'd1: kw_char = "a";
                3'd2: kw_char = "s";
                3'd3: kw_char = "e";
                default: kw_char = 8'h00;
            endcase
            default: case (p)
                3'd0: kw_char = "e";
                3'd1: kw_char = "n";
                3'd2: kw_char = "d";
                3'd3: kw_char = "c";
                3'd4: kw_char = "a";
                3'd5: kw_char = "s";
                3'd6: kw_char = "e";
                default: kw_char = 8'h00;
            endcase
        endcase
    endfunction

    logic [3:0]           len_q, len_d;
    logic [3:0]           alive_q, alive_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic [MAX_DEPTH-1:0] stack_q, stack_d;
    logic                 err_q, err_d;
    logic [1:0]           err_code_q, err_code_d;

    logic [7:0] byte_f;
    logic       is_space;
    logic [3:0] is_kw;
    logic       is_open, is_close;
    logic       open_kind, close_kind;
    logic       top_kind_w;
    logic       can_push, close_ok;

    // Decode the pending word and the stack top from registered state only.
    always_comb begin
        byte_f = bus.in;
        if (CASE_INSENSITIVE != 0 && bus.in >= "A" && bus.in <= "Z") begin
            byte_f = bus.in | 8'h20;
        end
        is_space = (bus.in == 8'h20);

        for (int k = 0; k < 4; k++) begin
            is_kw[k] = alive_q[k] && (len_q == kw_len(2'(k)));
        end
        is_open    = is_kw[0] | is_kw[2];
        open_kind  = is_kw[2];
        is_close   = is_kw[1] | is_kw[3];
        close_kind = is_kw[3];

        top_kind_w = 1'b0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (DEPTH_W'(i + 1) == depth_q) begin
                top_kind_w = stack_q[i];
            end
        end

        can_push = (depth_q < DEPTH_W'(MAX_DEPTH));
        close_ok = (depth_q != '0) && (top_kind_w == close_kind);
    end

    // Next-state: advance the word tracker, commit words on a space.
    always_comb begin
        len_d      = len_q;
        alive_d    = alive_q;
        depth_d    = depth_q;
        stack_d    = stack_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        if (bus.in_valid && !err_q) begin
            if (is_space) begin
                if (len_q != 4'd0) begin
                    if (is_open) begin
                        if (can_push) begin
                            for (int i = 0; i < MAX_DEPTH; i++) begin
                                if (DEPTH_W'(i) == depth_q) begin
                                    stack_d[i] = open_kind;
                                end
                            end
                            depth_d = depth_q + DEPTH_W'(1);
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_OVERFLOW;
                        end
                    end else if (is_close) begin
                        if (depth_q == '0) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_UNDERFLOW;
                        end else if (!close_ok) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_MISMATCH;
                        end else begin
                            depth_d = depth_q - DEPTH_W'(1);
                        end
                    end
                end
                len_d   = 4'd0;
                alive_d = 4'hF;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (len_q >= kw_len(2'(k)) || byte_f != kw_char(2'(k), len_q[2:0])) begin
                        alive_d[k] = 1'b0;
                    end
                end
                len_d = (len_q == LEN_SAT) ? LEN_SAT : len_q + 4'd1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q      <= 4'd0;
            alive_q    <= 4'hF;
            depth_q    <= '0;
            stack_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            len_q      <= len_d;
            alive_q    <= alive_d;
            depth_q    <= depth_d;
            stack_q    <= stack_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Balanced-if-word-ended-now preview.
    always_comb begin
        if (err_q) begin
            bus.result = 1'b0;
        end else if (is_open) begin
            bus.result = 1'b0;
        end else if (is_close) begin
            bus.result = close_ok && (depth_q == DEPTH_W'(1));
        end else begin
            bus.result = (depth_q == '0);
        end
    end

    assign bus.depth    = depth_q;
    assign bus.top_kind = top_kind_w;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_block_nest_checker.sv
// Bench for block_nest_checker. Three instances share one byte stream:
// dut0 default (depth 8, any case), dut1 depth 2, dut2 lowercase-only.
// A string/queue reference model predicts every output after every byte.
module tb_block_nest_checker;

    logic clk;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    block_nest_if #(.DEPTH_W(4)) bus0 ();
    block_nest_if #(.DEPTH_W(4)) bus1 ();
    block_nest_if #(.DEPTH_W(4)) bus2 ();

    block_nest_checker #(.MAX_DEPTH(8), .DEPTH_W(4), .CASE_INSENSITIVE(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));
    block_nest_checker #(.MAX_DEPTH(2), .DEPTH_W(4), .CASE_INSENSITIVE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));
    block_nest_checker #(.MAX_DEPTH(8), .DEPTH_W(4), .CASE_INSENSITIVE(0)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int    m_maxd [3] = '{8, 2, 8};
    bit    m_ci   [3] = '{1'b1, 1'b1, 1'b0};
    string m_word [3];
    bit    m_stk  [3][$];
    bit    m_err  [3];
    int    m_code [3];

    logic [8:0] exp_q[$];

    // 0 none, 1 begin, 2 end, 3 case, 4 endcase
    function automatic int kw_of(string w, bit ci);
        string f;
        f = ci ? w.tolower() : w;
        if (f == "begin")   return 1;
        if (f == "end")     return 2;
        if (f == "case")    return 3;
        if (f == "endcase") return 4;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_word[i] = "";
            m_stk[i].delete();
            m_err[i]  = 1'b0;
            m_code[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_step(input int i, input logic [7:0] b);
        int k;
        bit ck;
        if (m_err[i]) return;
        if (b != 8'h20) begin
            m_word[i] = $sformatf("%s%c", m_word[i], b);
        end else if (m_word[i].len() > 0) begin
            k = kw_of(m_word[i], m_ci[i]);
            if (k == 1 || k == 3) begin
                if (m_stk[i].size() < m_maxd[i]) m_stk[i].push_back(k == 3);
                else begin m_err[i] = 1'b1; m_code[i] = 3; end
            end else if (k == 2 || k == 4) begin
                ck = (k == 4);
                if (m_stk[i].size() == 0) begin m_err[i] = 1'b1; m_code[i] = 1; end
                else if (m_stk[i][m_stk[i].size()-1] != ck) begin m_err[i] = 1'b1; m_code[i] = 2; end
                else void'(m_stk[i].pop_back());
            end
            m_word[i] = "";
        end
    endtask

    // {result, top_kind, err, err_code, depth}
    function automatic logic [8:0] model_exp(input int i);
        int  k;
        int  sz;
        bit  r;
        bit  top;
        sz  = m_stk[i].size();
        top = (sz > 0) ? m_stk[i][sz-1] : 1'b0;
        k   = kw_of(m_word[i], m_ci[i]);
        if (m_err[i])                r = 1'b0;
        else if (k == 1 || k == 3)   r = 1'b0;
        else if (k == 2 || k == 4)   r = (sz == 1) && (top == (k == 4));
        else                         r = (sz == 0);
        return {r, top, m_err[i], 2'(m_code[i]), 4'(sz)};
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the next falling edge after
    // comparing all three instances with the model.
    task automatic drive_byte(input logic [7:0] b, input logic v);
        logic [8:0] obs [3];
        logic [8:0] exp_v;
        bus0.in = b; bus0.in_valid = v;
        bus1.in = b; bus1.in_valid = v;
        bus2.in = b; bus2.in_valid = v;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (v) model_step(i, b);
            exp_q.push_back(model_exp(i));
        end
        @(negedge clk);
        obs[0] = {bus0.result, bus0.top_kind, bus0.err, bus0.err_code, bus0.depth};
        obs[1] = {bus1.result, bus1.top_kind, bus1.err, bus1.err_code, bus1.depth};
        obs[2] = {bus2.result, bus2.top_kind, bus2.err, bus2.err_code, bus2.depth};
        for (int i = 0; i < 3; i++) begin
            exp_v = exp_q.pop_front();
            total++;
            if (obs[i] !== exp_v) begin
                bad++;
                $display("FAIL stream dut%0d byte=0x%02h valid=%0b: got {res,top,err,code,depth}=%03h want %03h",
                         i, b, v, obs[i], exp_v);
            end
        end
    endtask

    task automatic send_str(input string s, input int bubble_pct);
        for (int i = 0; i < s.len(); i++) begin
            while ($urandom_range(0, 99) < bubble_pct) drive_byte(8'($urandom), 1'b0);
            drive_byte(s[i], 1'b1);
        end
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++;
        if ({bus0.result, bus0.top_kind, bus0.err, bus0.err_code, bus0.depth} !== 9'h100) begin
            bad++; $display("FAIL reset_dut0: got %03h want 100",
                            {bus0.result, bus0.top_kind, bus0.err, bus0.err_code, bus0.depth});
        end
        total++;
        if ({bus1.result, bus1.top_kind, bus1.err, bus1.err_code, bus1.depth} !== 9'h100) begin
            bad++; $display("FAIL reset_dut1: got %03h want 100",
                            {bus1.result, bus1.top_kind, bus1.err, bus1.err_code, bus1.depth});
        end
        total++;
        if ({bus2.result, bus2.top_kind, bus2.err, bus2.err_code, bus2.depth} !== 9'h100) begin
            bad++; $display("FAIL reset_dut2: got %03h want 100",
                            {bus2.result, bus2.top_kind, bus2.err, bus2.err_code, bus2.depth});
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_str("begin", 0);
        total++;
        if (bus0.result !== 1'b0 || bus0.depth !== 4'd0) begin
            bad++; $display("FAIL basic_pending_begin: result=%0b depth=%0d want 0 0", bus0.result, bus0.depth);
        end
        send_str(" ", 0);
        total++;
        if (bus0.depth !== 4'd1 || bus0.result !== 1'b0) begin
            bad++; $display("FAIL basic_open: depth=%0d result=%0b want 1 0", bus0.depth, bus0.result);
        end
        send_str("end", 0);
        total++;
        if (bus0.result !== 1'b1 || bus0.depth !== 4'd1) begin
            bad++; $display("FAIL basic_preview_end: result=%0b depth=%0d want 1 1", bus0.result, bus0.depth);
        end
        send_str(" ", 0);
        total++;
        if (bus0.result !== 1'b1 || bus0.depth !== 4'd0 || bus0.err !== 1'b0) begin
            bad++; $display("FAIL basic_close: result=%0b depth=%0d err=%0b want 1 0 0",
                            bus0.result, bus0.depth, bus0.err);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        send_str("case begin end endcase ", 0);
        total++;
        if (bus0.depth !== 4'd0 || bus0.result !== 1'b1 || bus0.err !== 1'b0) begin
            bad++; $display("FAIL nest_two_kinds: depth=%0d result=%0b err=%0b want 0 1 0",
                            bus0.depth, bus0.result, bus0.err);
        end
        do_reset();
        send_str("case begin endcase ", 0);
        total++;
        if (bus0.err !== 1'b1 || bus0.err_code !== 2'd2 || bus0.depth !== 4'd2 || bus0.result !== 1'b0) begin
            bad++; $display("FAIL mismatch: err=%0b code=%0d depth=%0d result=%0b want 1 2 2 0",
                            bus0.err, bus0.err_code, bus0.depth, bus0.result);
        end
        send_str("end end ", 0);
        total++;
        if (bus0.err !== 1'b1 || bus0.err_code !== 2'd2 || bus0.depth !== 4'd2 || bus0.result !== 1'b0) begin
            bad++; $display("FAIL sticky: err=%0b code=%0d depth=%0d result=%0b want 1 2 2 0",
                            bus0.err, bus0.err_code, bus0.depth, bus0.result);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        send_str("end ", 0);
        total++;
        if (bus0.err !== 1'b1 || bus0.err_code !== 2'd1) begin
            bad++; $display("FAIL underflow: err=%0b code=%0d want 1 1", bus0.err, bus0.err_code);
        end
        do_reset();
        send_str("beginx end ", 0);
        total++;
        if (bus0.err_code !== 2'd1 || bus0.depth !== 4'd0) begin
            bad++; $display("FAIL beginx_ignored: code=%0d depth=%0d want 1 0", bus0.err_code, bus0.depth);
        end
        do_reset();
        send_str("endcasex ", 0);
        total++;
        if (bus0.err !== 1'b0 || bus0.result !== 1'b1) begin
            bad++; $display("FAIL endcasex_ignored: err=%0b result=%0b want 0 1", bus0.err, bus0.result);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_str("begin begin ", 0);
        total++;
        if (bus1.depth !== 4'd2 || bus1.err !== 1'b0) begin
            bad++; $display("FAIL overflow_fill: depth=%0d err=%0b want 2 0", bus1.depth, bus1.err);
        end
        send_str("begin ", 0);
        total++;
        if (bus1.err_code !== 2'd3 || bus1.depth !== 4'd2 || bus1.err !== 1'b1) begin
            bad++; $display("FAIL overflow: code=%0d depth=%0d err=%0b want 3 2 1",
                            bus1.err_code, bus1.depth, bus1.err);
        end
        total++;
        if (bus0.depth !== 4'd3 || bus0.err !== 1'b0) begin
            bad++; $display("FAIL deep_no_overflow: depth=%0d err=%0b want 3 0", bus0.depth, bus0.err);
        end
    endtask

    task automatic test_case_mode();
        do_reset();
        send_str("BeGiN  EnD ", 0);
        total++;
        if (bus0.result !== 1'b1 || bus0.depth !== 4'd0 || bus0.err !== 1'b0) begin
            bad++; $display("FAIL mixed_case: result=%0b depth=%0d err=%0b want 1 0 0",
                            bus0.result, bus0.depth, bus0.err);
        end
        do_reset();
        send_str("BEGIN ", 0);
        total++;
        if (bus2.depth !== 4'd0 || bus2.result !== 1'b1) begin
            bad++; $display("FAIL lowercase_only: depth=%0d result=%0b want 0 1", bus2.depth, bus2.result);
        end
        total++;
        if (bus0.depth !== 4'd1 || bus0.result !== 1'b0) begin
            bad++; $display("FAIL upper_open: depth=%0d result=%0b want 1 0", bus0.depth, bus0.result);
        end
    endtask

    task automatic test_bubble_reset();
        do_reset();
        send_str("beg", 0);
        for (int i = 0; i < 5; i++) drive_byte(($urandom_range(0, 1) == 0) ? 8'h20 : 8'($urandom), 1'b0);
        send_str("in ", 0);
        total++;
        if (bus0.depth !== 4'd1 || bus0.err !== 1'b0) begin
            bad++; $display("FAIL bubble_word: depth=%0d err=%0b want 1 0", bus0.depth, bus0.err);
        end
        send_str("en", 0);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (bus0.depth !== 4'd0 || bus0.err !== 1'b0 || bus0.result !== 1'b1 || bus0.top_kind !== 1'b0) begin
            bad++; $display("FAIL async_reset: depth=%0d err=%0b result=%0b top=%0b want 0 0 1 0",
                            bus0.depth, bus0.err, bus0.result, bus0.top_kind);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        send_str("end ", 0);
        total++;
        if (bus0.err_code !== 2'd1) begin
            bad++; $display("FAIL post_reset_underflow: code=%0d want 1", bus0.err_code);
        end
    endtask

    task automatic test_random();
        string words [14] = '{"begin", "end", "case", "endcase", "BEGIN", "End", "CaSe",
                              "ENDCASE", "beginx", "endcasex", "foo", "en",
                              "beginbeginx", "endcaseendcase"};
        for (int s = 0; s < 10; s++) begin
            do_reset();
            for (int w = 0; w < 16; w++) begin
                // bias toward opens early so deeper stacks are reached
                if (w < 5 && $urandom_range(0, 1) == 0)
                    send_str(($urandom_range(0, 1) == 0) ? "begin" : "case", 20);
                else
                    send_str(words[$urandom_range(0, 13)], 20);
                send_str(($urandom_range(0, 3) == 0) ? "  " : " ", 20);
            end
        end
    endtask

    // ---------------- sequencer / report ----------------
    initial begin
        reset_n = 1'b0;
        bus0.in = 8'h00; bus0.in_valid = 1'b0;
        bus1.in = 8'h00; bus1.in_valid = 1'b0;
        bus2.in = 8'h00; bus2.in_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        test_reset();
        test_basic();
        test_mismatch();
        test_underflow();
        test_overflow();
        test_case_mode();
        test_bubble_reset();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
